// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared constants, types and helpers for the VRAM arbiter
package vram_arb_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  localparam logic OWN_VID = 1'b0;
  localparam logic OWN_CPU = 1'b1;

  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] BOOST  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester, memory and read-return signals of the VRAM arbiter
interface vram_arbiter_if
  import vram_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, rdata, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/arb_tag_pipe.sv
// rtl/arb_tag_pipe.sv - {valid, owner} shift register that routes read data back to its requester
module arb_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_valid,
  input  logic issue_owner,
  output logic vid_rvalid,
  output logic cpu_rvalid,
  output logic cap_en
);

  tag_t [RD_LAT:0] pipe;
  tag_t            head;

  assign head = '{valid: issue_valid, owner: issue_owner};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[RD_LAT-1:0], head};
    end
  end

  // rdata is loaded on the same edge that moves a tag into the last stage
  assign cap_en     = pipe[RD_LAT-1].valid;
  assign vid_rvalid = pipe[RD_LAT].valid && (pipe[RD_LAT].owner == OWN_VID);
  assign cpu_rvalid = pipe[RD_LAT].valid && (pipe[RD_LAT].owner == OWN_CPU);

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - video/CPU arbiter for the shared single-port display memory
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  logic [0:0]    state;
  logic [7:0]    wait_cnt;
  logic [7:0]    wait_inc;
  logic          vid_win;
  logic          cpu_win;
  logic          cpu_wr;
  logic          rd_issue;
  logic          rd_owner;
  logic          cap_en;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rdata;

  always_comb begin
    vid_win = 1'b0;
    cpu_win = 1'b0;
    if (!reset) begin
      if (state == BOOST) begin
        cpu_win = bus.cpu_req;
        vid_win = bus.vid_req && !bus.cpu_req;
      end else begin
        vid_win = bus.vid_req;
        cpu_win = bus.cpu_req && !bus.vid_req;
      end
    end
  end

  assign bus.vid_gnt = vid_win;
  assign bus.cpu_gnt = cpu_win;
  assign cpu_wr      = cpu_win && bus.cpu_we;
  assign rd_issue    = vid_win || (cpu_win && !bus.cpu_we);
  assign rd_owner    = cpu_win ? OWN_CPU : OWN_VID;
  assign wait_inc    = sat_inc8(wait_cnt);

  // A stalled CPU can only be seen in NORMAL: BOOST always grants a requesting CPU
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= NORMAL;
      wait_cnt <= 8'd0;
    end else if (bus.cpu_req && !cpu_win) begin
      wait_cnt <= wait_inc;
      if (wait_inc == 8'(MAX_WAIT)) begin
        state <= BOOST;
      end
    end else begin
      wait_cnt <= 8'd0;
      state    <= NORMAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      mem_we <= cpu_wr;
      if (vid_win) begin
        mem_addr <= bus.vid_addr;
      end else if (cpu_win) begin
        mem_addr <= bus.cpu_addr;
      end
      if (cpu_wr) begin
        mem_wdata <= bus.cpu_wdata;
      end
      if (cap_en) begin
        rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;
  assign bus.rdata     = rdata;

  arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (rd_issue),
    .issue_owner (rd_owner),
    .vid_rvalid  (bus.vid_rvalid),
    .cpu_rvalid  (bus.cpu_rvalid),
    .cap_en      (cap_en)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized self-checking bench for vram_arbiter at RD_LAT=1 and RD_LAT=3
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;

  vram_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  vram_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

  vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_WAIT(MAX_WAIT)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_WAIT(MAX_WAIT)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  assign b1.vid_req = vid_req;  assign b1.vid_addr = vid_addr;
  assign b1.cpu_req = cpu_req;  assign b1.cpu_we = cpu_we;
  assign b1.cpu_addr = cpu_addr; assign b1.cpu_wdata = cpu_wdata;
  assign b3.vid_req = vid_req;  assign b3.vid_addr = vid_addr;
  assign b3.cpu_req = cpu_req;  assign b3.cpu_we = cpu_we;
  assign b3.cpu_addr = cpu_addr; assign b3.cpu_wdata = cpu_wdata;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 16'hA5C3 ^ {a[7:0], a[15:8]};
  endfunction

  // Memory block: both arbiters see the same request stream, so one array serves both
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  logic          mem_ready = 1'b0;
  logic [DW-1:0] d1, d2;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << AW); i++) env_mem[i] <= init_val(AW'(i));
      mem_ready <= 1'b1;
    end else if (b1.mem_we) begin
      env_mem[b1.mem_addr] <= b1.mem_wdata;
    end
    d1 <= env_mem[b3.mem_addr];
    d2 <= d1;
  end
  assign b1.mem_rdata = env_mem[b1.mem_addr];
  assign b3.mem_rdata = d2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int stall = 0;
  logic          sv1 [8], sc1 [8], sv3 [8], sc3 [8];
  logic [DW-1:0] sd1 [8], sd3 [8];
  logic [DW-1:0] er1 = '0, er3 = '0;
  logic [DW-1:0] model_mem [int];

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic idle();
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference model: CPU wins once it has waited MAX_WAIT cycles, else video first
  task automatic monitor();
    logic ev, ec;
    int s, s1, s3;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < 8; i++) begin sv1[i] = 1'b0; sv3[i] = 1'b0; end
        stall = 0; er1 = '0; er3 = '0;
        n_cmp++;
        if ({b1.vid_gnt, b1.cpu_gnt, b3.vid_gnt, b3.cpu_gnt} !== 4'b0000) begin
          n_bad++;
          $display("FAIL gnt_in_reset got %b required 0000", {b1.vid_gnt, b1.cpu_gnt, b3.vid_gnt, b3.cpu_gnt});
        end
      end else begin
        ec = cpu_req && (!vid_req || stall >= MAX_WAIT);
        ev = vid_req && !ec;
        n_cmp++;
        if ({b1.vid_gnt, b1.cpu_gnt} !== {ev, ec}) begin
          n_bad++; $display("FAIL grant_lat1 cyc %0d got %b required %b", cyc, {b1.vid_gnt, b1.cpu_gnt}, {ev, ec});
        end
        n_cmp++;
        if ({b3.vid_gnt, b3.cpu_gnt} !== {ev, ec}) begin
          n_bad++; $display("FAIL grant_lat3 cyc %0d got %b required %b", cyc, {b3.vid_gnt, b3.cpu_gnt}, {ev, ec});
        end
        s = cyc % 8;
        if (sv1[s]) er1 = sd1[s];
        if (sv3[s]) er3 = sd3[s];
        n_cmp++;
        if ({b1.vid_rvalid, b1.cpu_rvalid, b1.rdata} !== {sv1[s] && !sc1[s], sv1[s] && sc1[s], er1}) begin
          n_bad++;
          $display("FAIL return_lat1 cyc %0d got v%b c%b %h required v%b c%b %h", cyc, b1.vid_rvalid, b1.cpu_rvalid,
                   b1.rdata, sv1[s] && !sc1[s], sv1[s] && sc1[s], er1);
        end
        n_cmp++;
        if ({b3.vid_rvalid, b3.cpu_rvalid, b3.rdata} !== {sv3[s] && !sc3[s], sv3[s] && sc3[s], er3}) begin
          n_bad++;
          $display("FAIL return_lat3 cyc %0d got v%b c%b %h required v%b c%b %h", cyc, b3.vid_rvalid, b3.cpu_rvalid,
                   b3.rdata, sv3[s] && !sc3[s], sv3[s] && sc3[s], er3);
        end
        sv1[s] = 1'b0; sv3[s] = 1'b0;
        if (cpu_req && !ec) stall = (stall < 255) ? stall + 1 : 255;
        else stall = 0;
        if (ev || (ec && !cpu_we)) begin
          s1 = (cyc + 2) % 8; s3 = (cyc + 4) % 8;
          sv1[s1] = 1'b1; sc1[s1] = ec; sd1[s1] = model_rd(ev ? vid_addr : cpu_addr);
          sv3[s3] = 1'b1; sc3[s3] = ec; sd3[s3] = model_rd(ev ? vid_addr : cpu_addr);
        end
        if (ec && cpu_we) model_mem[int'(cpu_addr)] = cpu_wdata;
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; vid_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    cycles(2);
    n_cmp++;
    if ({b1.mem_addr, b1.mem_we, b1.mem_wdata, b1.rdata, b1.vid_rvalid, b1.cpu_rvalid, b1.vid_gnt, b1.cpu_gnt,
         b3.mem_addr, b3.mem_we, b3.mem_wdata, b3.rdata, b3.vid_rvalid, b3.cpu_rvalid, b3.vid_gnt, b3.cpu_gnt} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got addr %h we %b rdata %h gnt %b%b required all zero",
                        b1.mem_addr, b1.mem_we, b1.rdata, b1.vid_gnt, b1.cpu_gnt);
    end
    idle();
    reset = 1'b0;
    n_cmp++;
    if ({dut1.state, dut1.wait_cnt, dut3.state, dut3.wait_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_state got %b/%0d required NORMAL/0", dut1.state, dut1.wait_cnt);
    end
    cycles(3);
  endtask

  task automatic test_cpu_read();
    logic [DW-1:0] want;
    want = model_rd(16'h0123);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
    @(negedge clk);
    n_cmp++;
    if ({b1.vid_gnt, b1.cpu_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL cpu_read_gnt got %b required 01", {b1.vid_gnt, b1.cpu_gnt});
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    n_cmp++;
    if ({b1.mem_addr, b1.mem_we} !== {16'h0123, 1'b0}) begin
      n_bad++; $display("FAIL cpu_read_addr got %h we %b required 0123 we 0", b1.mem_addr, b1.mem_we);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({b1.cpu_rvalid, b1.vid_rvalid, b1.rdata} !== {2'b10, want}) begin
      n_bad++; $display("FAIL cpu_read_data got c%b v%b %h required c1 v0 %h", b1.cpu_rvalid, b1.vid_rvalid, b1.rdata, want);
    end
    cycles(5);
  endtask

  task automatic test_contention();
    logic [11:0] got;
    vid_req = 1'b1; vid_addr = 16'h3000; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3100;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      got[i] = b1.cpu_gnt;
      n_cmp++;
      if ((b1.vid_gnt ^ b1.cpu_gnt) !== 1'b1) begin
        n_bad++; $display("FAIL contention_one_grant cyc %0d got %b%b required exactly one", i, b1.vid_gnt, b1.cpu_gnt);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got !== 12'b0001_0000_0000) begin
      n_bad++; $display("FAIL contention_pattern got %b required 000100000000", got);
    end
    idle();
    cycles(6);
  endtask

  task automatic test_write_read();
    int we_cnt = 0;
    logic vid_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF; end
      if (i == 1) begin cpu_we = 1'b0; end
      if (i == 2) idle();
      @(negedge clk);
      if (b1.mem_we) we_cnt++;
      vid_seen = vid_seen | b1.vid_rvalid | b3.vid_rvalid;
      if (i == 3) begin
        n_cmp++;
        if ({b1.cpu_rvalid, b1.rdata} !== {1'b1, 16'hBEEF}) begin
          n_bad++; $display("FAIL wr_rd_lat1 got c%b %h required c1 beef", b1.cpu_rvalid, b1.rdata);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if ({b3.cpu_rvalid, b3.rdata} !== {1'b1, 16'hBEEF}) begin
          n_bad++; $display("FAIL wr_rd_lat3 got c%b %h required c1 beef", b3.cpu_rvalid, b3.rdata);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (we_cnt !== 1) begin n_bad++; $display("FAIL wr_rd_we_count got %0d required 1", we_cnt); end
    n_cmp++;
    if (vid_seen !== 1'b0) begin n_bad++; $display("FAIL wr_rd_vid_rvalid got 1 required 0"); end
    cycles(2);
  endtask

  task automatic test_stream();
    logic [15:0]   got1 = '0, got3 = '0;
    logic [DW-1:0] want [3];
    logic [DW-1:0] gd1 [3], gd3 [3];
    int k1 = 0, k3 = 0;
    want[0] = model_rd(16'h1000); want[1] = model_rd(16'h1001); want[2] = model_rd(16'h2000);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin vid_req = 1'b1; vid_addr = 16'h1000; end
      if (i == 1) vid_addr = 16'h1001;
      if (i == 2) begin vid_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000; end
      if (i == 3) idle();
      @(negedge clk);
      got1 = {got1[13:0], b1.vid_rvalid, b1.cpu_rvalid};
      got3 = {got3[13:0], b3.vid_rvalid, b3.cpu_rvalid};
      if ((b1.vid_rvalid || b1.cpu_rvalid) && k1 < 3) begin gd1[k1] = b1.rdata; k1++; end
      if ((b3.vid_rvalid || b3.cpu_rvalid) && k3 < 3) begin gd3[k3] = b3.rdata; k3++; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got1 !== 16'h0A40) begin n_bad++; $display("FAIL stream_order_lat1 got %h required 0a40", got1); end
    n_cmp++;
    if (got3 !== 16'h00A4) begin n_bad++; $display("FAIL stream_order_lat3 got %h required 00a4", got3); end
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (j >= k1 || gd1[j] !== want[j] || j >= k3 || gd3[j] !== want[j]) begin
        n_bad++; $display("FAIL stream_data %0d got %h/%h required %h", j, gd1[j], gd3[j], want[j]);
      end
    end
    cycles(2);
  endtask

  task automatic test_random();
    int multi = 0;
    logic vg, cg;
    for (int i = 0; i < 400; i++) begin
      if (!vid_req && $urandom_range(0, 2) == 0) begin
        vid_req = 1'b1; vid_addr = 16'($urandom_range(0, 7));
      end
      if (!cpu_req && $urandom_range(0, 1) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 16'($urandom_range(0, 7)); cpu_wdata = 16'($urandom);
      end
      @(negedge clk);
      vg = b1.vid_gnt; cg = b1.cpu_gnt;
      if (vg && cg) multi++;
      @(posedge clk); #1;
      if (vg) vid_req = 1'b0;
      if (cg) cpu_req = 1'b0;
    end
    n_cmp++;
    if (multi !== 0) begin n_bad++; $display("FAIL random_double_grant got %0d required 0", multi); end
    idle();
    cycles(6);
  endtask

  task automatic test_reset_midflight();
    logic seen = 1'b0;
    vid_req = 1'b1; vid_addr = 16'h1234; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0777;
    @(negedge clk);
    n_cmp++;
    if ({b1.vid_gnt, b1.cpu_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL midflight_gnt got %b required 10", {b1.vid_gnt, b1.cpu_gnt});
    end
    @(posedge clk); #1;
    idle();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({b1.mem_addr, b1.mem_we, b1.mem_wdata, b1.rdata, b1.vid_rvalid, b1.cpu_rvalid,
         b3.mem_addr, b3.mem_we, b3.mem_wdata, b3.rdata, b3.vid_rvalid, b3.cpu_rvalid,
         dut1.state, dut1.wait_cnt, dut3.state, dut3.wait_cnt} !== '0) begin
      n_bad++; $display("FAIL midflight_async_reset got addr %h rdata %h wait %0d required all zero",
                        b1.mem_addr, b1.rdata, dut1.wait_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | b1.vid_rvalid | b3.vid_rvalid | b1.cpu_rvalid | b3.cpu_rvalid;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL midflight_stale_rvalid got 1 required 0"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    vid_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_cpu_read();
    test_contention();
    test_write_read();
    test_stream();
    test_random();
    test_reset_midflight();
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
